film_effect_scheduler: RTL and testbench

- Frame-synchronous controller for the old-film RGB processing datapath.
- Shadows user switch and key settings and commits them only at frame start, so the datapath never changes mode mid-frame.
- Once per frame (or per N frames, key-selected), steps a 16-bit LFSR to generate flicker gain, grain seed and a drifting vertical scratch column.
- Sits between board switches/keys/VGA_VS and the pixel datapath's configuration inputs.

---
 rtl/film_effect_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_film_effect_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/film_effect_scheduler.sv
// Frame-synchronous configuration and film-effect controller: commits switch settings at
// frame start and steps an LFSR every N frames to drive flicker, grain seed and a scratch column.
module film_effect_scheduler #(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter logic [7:0]  SCRATCH_PROB = 8'd16,
    parameter logic [5:0]  SCRATCH_LIFE = 6'd40,
    parameter logic [9:0]  H_ACTIVE     = 10'd640
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vga_vs,
    input  logic        effect_en,
    input  logic [5:0]  filter_sw,
    input  logic        grayscale_sw,
    input  logic        sepia_sw,
    input  logic        vignette_sw,
    input  logic [3:0]  key_speed,
    output logic [5:0]  cfg_filter,
    output logic        cfg_grayscale,
    output logic        cfg_sepia,
    output logic        cfg_vignette,
    output logic [7:0]  flicker_gain,
    output logic [15:0] grain_seed,
    output logic [9:0]  scratch_col,
    output logic        scratch_valid,
    output logic        frame_strobe,
    output logic [15:0] frame_count,
    output logic        overrun
);

    localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {IDLE, ARMED, UPDATE, APPLY} state_t;

    state_t      state_q, state_d;
    logic        vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d, vs_s3_q, vs_s3_d;
    logic        frame_strobe_q, frame_strobe_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [5:0]  cfg_filter_q, cfg_filter_d;
    logic        cfg_grayscale_q, cfg_grayscale_d;
    logic        cfg_sepia_q, cfg_sepia_d;
    logic        cfg_vignette_q, cfg_vignette_d;
    logic [2:0]  interval_q, interval_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  flicker_q, flicker_d;
    logic [15:0] grain_q, grain_d;
    logic [9:0]  col_q, col_d;
    logic        valid_q, valid_d;
    logic [5:0]  life_q, life_d;
    logic        overrun_q, overrun_d;

    logic        fall;
    logic        ival_chg;
    logic [2:0]  key_ival;
    logic [15:0] lfsr_step;
    logic [9:0]  spawn_raw, spawn_col;
    logic [5:0]  life_nxt;

    // Interval stored as reload value (frames - 1); highest pressed key wins.
    always_comb begin
        if (key_speed[3])      key_ival = 3'd7;
        else if (key_speed[2]) key_ival = 3'd3;
        else if (key_speed[1]) key_ival = 3'd1;
        else                   key_ival = 3'd0;
    end

    assign fall      = vs_s3_q & ~vs_s2_q;
    assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
    assign spawn_raw = lfsr_q[15:6];
    assign spawn_col = (spawn_raw >= H_ACTIVE) ? (spawn_raw - H_ACTIVE) : spawn_raw;
    assign life_nxt  = life_q - 6'd1;

    always_comb begin
        state_d         = state_q;
        vs_s1_d         = vga_vs;
        vs_s2_d         = vs_s1_q;
        vs_s3_d         = vs_s2_q;
        frame_strobe_d  = fall;
        frame_count_d   = frame_count_q;
        cfg_filter_d    = cfg_filter_q;
        cfg_grayscale_d = cfg_grayscale_q;
        cfg_sepia_d     = cfg_sepia_q;
        cfg_vignette_d  = cfg_vignette_q;
        interval_d      = interval_q;
        cnt_d           = cnt_q;
        lfsr_d          = lfsr_q;
        flicker_d       = flicker_q;
        grain_d         = grain_q;
        col_d           = col_q;
        valid_d         = valid_q;
        life_d          = life_q;
        overrun_d       = overrun_q;
        ival_chg        = 1'b0;

        if (fall) begin
            frame_count_d   = frame_count_q + 16'd1;
            cfg_filter_d    = filter_sw;
            cfg_grayscale_d = grayscale_sw;
            cfg_sepia_d     = sepia_sw;
            cfg_vignette_d  = vignette_sw;
            if ((|key_speed) && (key_ival != interval_q)) begin
                ival_chg   = 1'b1;
                interval_d = key_ival;
                cnt_d      = key_ival;
            end
        end

        case (state_q)
            IDLE: begin
                flicker_d = 8'd255;
                valid_d   = 1'b0;
                if (fall && effect_en) state_d = ARMED;
            end
            ARMED: begin
                if (fall) begin
                    if (!effect_en) begin
                        state_d = IDLE;
                    end else if (!ival_chg) begin
                        if (cnt_q == 3'd0) begin
                            cnt_d   = interval_q;
                            state_d = UPDATE;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end
            end
            UPDATE: begin
                lfsr_d  = lfsr_step;
                state_d = APPLY;
                if (fall) overrun_d = 1'b1;
            end
            APPLY: begin
                flicker_d = 8'd224 + {3'b000, lfsr_q[4:0]};
                grain_d   = lfsr_q;
                if (valid_q) begin
                    life_d = life_nxt;
                    if (lfsr_q[8]) begin
                        if (col_q < H_ACTIVE - 10'd1) col_d = col_q + 10'd1;
                    end else begin
                        if (col_q != 10'd0) col_d = col_q - 10'd1;
                    end
                    if (life_nxt == 6'd0) valid_d = 1'b0;
                end else if (lfsr_q[7:0] < SCRATCH_PROB) begin
                    col_d   = spawn_col;
                    life_d  = SCRATCH_LIFE;
                    valid_d = 1'b1;
                end
                state_d = ARMED;
                if (fall) overrun_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sync flops reset high so an idle-high vga_vs produces no strobe after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            vs_s1_q         <= 1'b1;
            vs_s2_q         <= 1'b1;
            vs_s3_q         <= 1'b1;
            frame_strobe_q  <= 1'b0;
            frame_count_q   <= 16'd0;
            cfg_filter_q    <= 6'd0;
            cfg_grayscale_q <= 1'b0;
            cfg_sepia_q     <= 1'b0;
            cfg_vignette_q  <= 1'b0;
            interval_q      <= 3'd0;
            cnt_q           <= 3'd0;
            lfsr_q          <= SEED;
            flicker_q       <= 8'd255;
            grain_q         <= SEED;
            col_q           <= 10'd0;
            valid_q         <= 1'b0;
            life_q          <= 6'd0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            vs_s1_q         <= vs_s1_d;
            vs_s2_q         <= vs_s2_d;
            vs_s3_q         <= vs_s3_d;
            frame_strobe_q  <= frame_strobe_d;
            frame_count_q   <= frame_count_d;
            cfg_filter_q    <= cfg_filter_d;
            cfg_grayscale_q <= cfg_grayscale_d;
            cfg_sepia_q     <= cfg_sepia_d;
            cfg_vignette_q  <= cfg_vignette_d;
            interval_q      <= interval_d;
            cnt_q           <= cnt_d;
            lfsr_q          <= lfsr_d;
            flicker_q       <= flicker_d;
            grain_q         <= grain_d;
            col_q           <= col_d;
            valid_q         <= valid_d;
            life_q          <= life_d;
            overrun_q       <= overrun_d;
        end
    end

    assign cfg_filter    = cfg_filter_q;
    assign cfg_grayscale = cfg_grayscale_q;
    assign cfg_sepia     = cfg_sepia_q;
    assign cfg_vignette  = cfg_vignette_q;
    assign flicker_gain  = flicker_q;
    assign grain_seed    = grain_q;
    assign scratch_col   = col_q;
    assign scratch_valid = valid_q;
    assign frame_strobe  = frame_strobe_q;
    assign frame_count   = frame_count_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_film_effect_scheduler.sv
// Directed bench for film_effect_scheduler: default instance for sync/cfg/interval/overrun/reset,
// second instance with a high scratch probability and short life for the scratch path.
module tb_film_effect_scheduler;

    logic        clk = 1'b0;
    logic        reset, vga_vs, effect_en;
    logic [5:0]  filter_sw;
    logic        grayscale_sw, sepia_sw, vignette_sw;
    logic [3:0]  key_speed;

    logic [5:0]  a_cfg_filter, b_cfg_filter;
    logic        a_cfg_grayscale, a_cfg_sepia, a_cfg_vignette;
    logic        b_cfg_grayscale, b_cfg_sepia, b_cfg_vignette;
    logic [7:0]  a_flicker, b_flicker;
    logic [15:0] a_grain, b_grain;
    logic [9:0]  a_col, b_col;
    logic        a_valid, b_valid, a_strobe, b_strobe, a_overrun, b_overrun;
    logic [15:0] a_count, b_count;

    int tests = 0;
    int fails = 0;

    always #10 clk = ~clk;

    film_effect_scheduler dut_a (
        .clk(clk), .reset(reset), .vga_vs(vga_vs), .effect_en(effect_en),
        .filter_sw(filter_sw), .grayscale_sw(grayscale_sw), .sepia_sw(sepia_sw),
        .vignette_sw(vignette_sw), .key_speed(key_speed),
        .cfg_filter(a_cfg_filter), .cfg_grayscale(a_cfg_grayscale), .cfg_sepia(a_cfg_sepia),
        .cfg_vignette(a_cfg_vignette), .flicker_gain(a_flicker), .grain_seed(a_grain),
        .scratch_col(a_col), .scratch_valid(a_valid), .frame_strobe(a_strobe),
        .frame_count(a_count), .overrun(a_overrun)
    );

    film_effect_scheduler #(.SCRATCH_PROB(8'd255), .SCRATCH_LIFE(6'd3)) dut_b (
        .clk(clk), .reset(reset), .vga_vs(vga_vs), .effect_en(effect_en),
        .filter_sw(filter_sw), .grayscale_sw(grayscale_sw), .sepia_sw(sepia_sw),
        .vignette_sw(vignette_sw), .key_speed(key_speed),
        .cfg_filter(b_cfg_filter), .cfg_grayscale(b_cfg_grayscale), .cfg_sepia(b_cfg_sepia),
        .cfg_vignette(b_cfg_vignette), .flicker_gain(b_flicker), .grain_seed(b_grain),
        .scratch_col(b_col), .scratch_valid(b_valid), .frame_strobe(b_strobe),
        .frame_count(b_count), .overrun(b_overrun)
    );

    typedef struct {
        logic [5:0]  f;
        logic        g, s, v;
        logic [15:0] grain;
    } cfg_vec_t;

    typedef struct {
        logic        valid;
        logic [9:0]  col;
        logic [15:0] grain;
        logic [7:0]  flicker;
    } scr_vec_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        @(negedge clk) vga_vs = 1'b0;
        tick();
        tick();
        chk("strobe_early", {31'd0, a_strobe}, 32'd0);
        tick();
        chk("strobe", {31'd0, a_strobe}, 32'd1);
    endtask

    task automatic frame_end();
        tick();
        chk("strobe_one_cycle", {31'd0, a_strobe}, 32'd0);
        repeat (2) tick();
        @(negedge clk) vga_vs = 1'b1;
        repeat (5) tick();
    endtask

    task automatic frame();
        frame_start();
        frame_end();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_vec_t    tbl[3];
        scr_vec_t    stbl[5];
        cfg_vec_t    prev;
        logic [15:0] exp_lf;
        logic [15:0] exp_cnt;

        tbl[0] = '{f: 6'h15, g: 1'b0, s: 1'b1, v: 1'b0, grain: 16'h7138};
        tbl[1] = '{f: 6'h2A, g: 1'b1, s: 1'b0, v: 1'b1, grain: 16'h389C};
        tbl[2] = '{f: 6'h3F, g: 1'b1, s: 1'b1, v: 1'b1, grain: 16'h1C4E};

        stbl[0] = '{valid: 1'b1, col: 10'd265, grain: 16'hE270, flicker: 8'd240};
        stbl[1] = '{valid: 1'b1, col: 10'd266, grain: 16'h7138, flicker: 8'd248};
        stbl[2] = '{valid: 1'b1, col: 10'd265, grain: 16'h389C, flicker: 8'd252};
        stbl[3] = '{valid: 1'b0, col: 10'd264, grain: 16'h1C4E, flicker: 8'd238};
        stbl[4] = '{valid: 1'b1, col: 10'd56,  grain: 16'h0E27, flicker: 8'd231};

        reset = 1'b1; vga_vs = 1'b1; effect_en = 1'b0;
        filter_sw = 6'd0; grayscale_sw = 1'b0; sepia_sw = 1'b0; vignette_sw = 1'b0;
        key_speed = 4'd0;
        repeat (3) tick();
        @(negedge clk) reset = 1'b0;
        tick();

        chk("rst_flicker", {24'd0, a_flicker}, 32'd255);
        chk("rst_grain", {16'd0, a_grain}, 32'hACE1);
        chk("rst_count", {16'd0, a_count}, 32'd0);
        chk("rst_cfg", {26'd0, a_cfg_filter}, 32'd0);
        chk("rst_valid_col", {21'd0, a_valid, a_col}, 32'd0);
        chk("rst_overrun_strobe", {30'd0, a_overrun, a_strobe}, 32'd0);

        // First strobe: IDLE -> ARMED, no update yet.
        @(negedge clk) effect_en = 1'b1;
        frame();
        chk("f1_count", {16'd0, a_count}, 32'd1);
        chk("f1_grain", {16'd0, a_grain}, 32'hACE1);

        // Second strobe: outputs land two cycles after the strobe.
        frame_start();
        chk("f2_grain_strobe", {16'd0, a_grain}, 32'hACE1);
        tick();
        chk("f2_grain_update", {16'd0, a_grain}, 32'hACE1);
        tick();
        chk("f2_grain", {16'd0, a_grain}, 32'hE270);
        chk("f2_flicker", {24'd0, a_flicker}, 32'd240);
        chk("f2_valid", {31'd0, a_valid}, 32'd0);
        repeat (2) tick();
        @(negedge clk) vga_vs = 1'b1;
        repeat (5) tick();
        chk("f2_count", {16'd0, a_count}, 32'd2);
        exp_lf = 16'hE270;
        exp_cnt = 16'd2;

        // cfg shadowing: switch changes mid-frame only appear at the strobe.
        prev = '{f: 6'd0, g: 1'b0, s: 1'b0, v: 1'b0, grain: 16'h0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            filter_sw = tbl[i].f; grayscale_sw = tbl[i].g;
            sepia_sw = tbl[i].s; vignette_sw = tbl[i].v;
            tick();
            chk("cfg_hold", {22'd0, a_cfg_filter, a_cfg_grayscale, a_cfg_sepia, a_cfg_vignette},
                {22'd0, prev.f, prev.g, prev.s, prev.v});
            frame_start();
            chk("cfg_commit", {22'd0, a_cfg_filter, a_cfg_grayscale, a_cfg_sepia, a_cfg_vignette},
                {22'd0, tbl[i].f, tbl[i].g, tbl[i].s, tbl[i].v});
            frame_end();
            exp_cnt++;
            chk("cfg_grain", {16'd0, a_grain}, {16'd0, tbl[i].grain});
            chk("cfg_count", {16'd0, a_count}, {16'd0, exp_cnt});
            prev = tbl[i];
        end
        exp_lf = 16'h1C4E;

        // Interval 4 via key2; release keeps it.
        @(negedge clk) key_speed = 4'b0100;
        frame();
        chk("ival4_load", {16'd0, a_grain}, {16'd0, exp_lf});
        @(negedge clk) key_speed = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            frame();
            if (k % 4 == 0) exp_lf = lfsr_next(exp_lf);
            chk("ival4", {16'd0, a_grain}, {16'd0, exp_lf});
        end

        // Key3 beats key0: interval 8.
        @(negedge clk) key_speed = 4'b1001;
        frame();
        chk("ival8_load", {16'd0, a_grain}, {16'd0, exp_lf});
        @(negedge clk) key_speed = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            frame();
            if (k == 8) exp_lf = lfsr_next(exp_lf);
            chk("ival8", {16'd0, a_grain}, {16'd0, exp_lf});
        end
        exp_cnt = exp_cnt + 16'd18;
        chk("ival_count", {16'd0, a_count}, {16'd0, exp_cnt});

        // Disable at an ARMED strobe; back to interval 1 at the same time.
        @(negedge clk) begin key_speed = 4'b0001; effect_en = 1'b0; end
        frame();
        @(negedge clk) key_speed = 4'b0000;
        chk("idle_flicker", {24'd0, a_flicker}, 32'd255);
        chk("idle_valid", {31'd0, a_valid}, 32'd0);
        @(negedge clk) filter_sw = 6'h0A;
        frame();
        chk("idle_cfg", {26'd0, a_cfg_filter}, 32'h0A);
        frame();
        chk("idle_frozen", {16'd0, a_grain}, {16'd0, exp_lf});
        @(negedge clk) effect_en = 1'b1;
        frame();
        chk("rearm_no_update", {16'd0, a_grain}, {16'd0, exp_lf});
        frame();
        exp_lf = lfsr_next(exp_lf);
        chk("rearm_update", {16'd0, a_grain}, {16'd0, exp_lf});
        exp_cnt = exp_cnt + 16'd5;
        chk("idle_count", {16'd0, a_count}, {16'd0, exp_cnt});

        // Overrun: second falling edge lands while the FSM is in APPLY.
        chk("overrun_clear", {31'd0, a_overrun}, 32'd0);
        @(negedge clk) vga_vs = 1'b0;
        @(negedge clk) vga_vs = 1'b1;
        @(negedge clk) vga_vs = 1'b0;
        repeat (6) tick();
        @(negedge clk) vga_vs = 1'b1;
        repeat (5) tick();
        exp_lf = lfsr_next(exp_lf);
        exp_cnt = exp_cnt + 16'd2;
        chk("overrun_set", {31'd0, a_overrun}, 32'd1);
        chk("overrun_count", {16'd0, a_count}, {16'd0, exp_cnt});
        chk("overrun_grain", {16'd0, a_grain}, {16'd0, exp_lf});
        frame();
        exp_lf = lfsr_next(exp_lf);
        chk("overrun_sticky", {31'd0, a_overrun}, 32'd1);
        chk("overrun_next_grain", {16'd0, a_grain}, {16'd0, exp_lf});

        // Reset while in APPLY.
        frame_start();
        tick();
        @(negedge clk) reset = 1'b1;
        tick();
        chk("mid_rst_flicker", {24'd0, a_flicker}, 32'd255);
        chk("mid_rst_grain", {16'd0, a_grain}, 32'hACE1);
        chk("mid_rst_count", {16'd0, a_count}, 32'd0);
        chk("mid_rst_overrun", {31'd0, a_overrun}, 32'd0);
        chk("mid_rst_cfg", {26'd0, a_cfg_filter}, 32'd0);
        @(negedge clk) vga_vs = 1'b1;
        repeat (3) tick();
        @(negedge clk) reset = 1'b0;
        tick();

        // Scratch lifecycle on the high-probability instance.
        frame();
        chk("scr_armed", {21'd0, b_valid, b_col}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            frame();
            chk("scr_valid", {31'd0, b_valid}, {31'd0, stbl[i].valid});
            chk("scr_col", {22'd0, b_col}, {22'd0, stbl[i].col});
            chk("scr_grain", {16'd0, b_grain}, {16'd0, stbl[i].grain});
            chk("scr_flicker", {24'd0, b_flicker}, {24'd0, stbl[i].flicker});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
